// File: rtl/mor1kx_rf_ram_2r1w_if.sv
// Request/response bundle for the two-read, one-write register-file RAM.
// The master drives addresses, enables and write data. The slave returns read data and busy.
interface mor1kx_rf_ram_2r1w_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic [AW-1:0] rdad_a_i;
    logic          rden_a_i;
    logic [DW-1:0] rdda_a_o;
    logic [AW-1:0] rdad_b_i;
    logic          rden_b_i;
    logic [DW-1:0] rdda_b_o;
    logic [AW-1:0] wrad_i;
    logic          wren_i;
    logic [DW-1:0] wrda_i;
    logic          busy_o;

    modport master (
        output rdad_a_i, rden_a_i, rdad_b_i, rden_b_i, wrad_i, wren_i, wrda_i,
        input  rdda_a_o, rdda_b_o, busy_o
    );

    modport slave (
        input  rdad_a_i, rden_a_i, rdad_b_i, rden_b_i, wrad_i, wren_i, wrda_i,
        output rdda_a_o, rdda_b_o, busy_o
    );
endinterface

// File: rtl/mor1kx_rf_ram_2r1w.sv
// Register-file RAM with two registered read ports and one write port.
// It can forward write data to a read, clear every word after reset, and guards against out-of-range addresses.
//
// state    | meaning
// ST_CLEAR | zeroing ram[clr_cnt_q] each cycle, all requests ignored, busy_o=1
// ST_READY | normal read/write service until the next reset
module mor1kx_rf_ram_2r1w #(
    parameter int OPTION_OPERAND_WIDTH     = 32,
    parameter int OPTION_RF_ADDR_WIDTH     = 5,
    parameter int OPTION_RF_WORDS          = 32,
    parameter int OPTION_RF_BYPASS         = 1,
    parameter int OPTION_RF_CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    mor1kx_rf_ram_2r1w_if.slave     rf
);
    localparam int AW = OPTION_RF_ADDR_WIDTH;
    localparam int DW = OPTION_OPERAND_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t        RST_STATE = (OPTION_RF_CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    localparam logic [AW-1:0] LAST_WORD = AW'(OPTION_RF_WORDS - 1);
    // One extra bit so OPTION_RF_WORDS == 2**AW still compares correctly.
    localparam logic [AW:0]   WORDS_W   = (AW+1)'(OPTION_RF_WORDS);
    localparam logic          BYPASS_EN = (OPTION_RF_BYPASS != 0);

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [DW-1:0] rdda_a_q, rdda_a_d;
    logic [DW-1:0] rdda_b_q, rdda_b_d;

    logic [DW-1:0] mem [OPTION_RF_WORDS];

    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_wd;

    logic          wr_in_range;
    logic          rd_in_range_a, rd_in_range_b;
    logic          fwd_a, fwd_b;
    logic [DW-1:0] rd_word_a, rd_word_b;

    assign wr_in_range   = ({1'b0, rf.wrad_i}   < WORDS_W);
    assign rd_in_range_a = ({1'b0, rf.rdad_a_i} < WORDS_W);
    assign rd_in_range_b = ({1'b0, rf.rdad_b_i} < WORDS_W);

    // Forwarding only matters for a real write to an implemented word.
    assign fwd_a = BYPASS_EN && rf.wren_i && wr_in_range && (rf.wrad_i == rf.rdad_a_i);
    assign fwd_b = BYPASS_EN && rf.wren_i && wr_in_range && (rf.wrad_i == rf.rdad_b_i);

    assign rd_word_a = !rd_in_range_a ? '0 : (fwd_a ? rf.wrda_i : mem[rf.rdad_a_i]);
    assign rd_word_b = !rd_in_range_b ? '0 : (fwd_b ? rf.wrda_i : mem[rf.rdad_b_i]);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rdda_a_d  = rdda_a_q;
        rdda_b_d  = rdda_b_q;
        ram_we    = 1'b0;
        ram_wa    = rf.wrad_i;
        ram_wd    = rf.wrda_i;

        case (state_q)
            ST_CLEAR: begin
                ram_we = 1'b1;
                ram_wa = clr_cnt_q;
                ram_wd = '0;
                if (clr_cnt_q == LAST_WORD) begin
                    state_d = ST_READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                ram_we = rf.wren_i && wr_in_range;
                if (rf.rden_a_i) rdda_a_d = rd_word_a;
                if (rf.rden_b_i) rdda_b_d = rd_word_b;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
            rdda_a_q  <= '0;
            rdda_b_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rdda_a_q  <= rdda_a_d;
            rdda_b_q  <= rdda_b_d;
        end
    end

    // The storage array has no reset; the clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_wa] <= ram_wd;
        end
    end

    assign rf.rdda_a_o = rdda_a_q;
    assign rf.rdda_b_o = rdda_b_q;
    assign rf.busy_o   = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_mor1kx_rf_ram_2r1w.sv
// Two instances share one stimulus stream: the defaults, and a 24-word variant without bypass.
// A behavioural array model predicts both.
module tb_mor1kx_rf_ram_2r1w;
    logic        clk;
    logic        rst;
    logic [4:0]  rdad_a, rdad_b, wrad;
    logic        rden_a, rden_b, wren;
    logic [31:0] wrda;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    logic [31:0] exp_aa, exp_ab, exp_ba, exp_bb;

    mor1kx_rf_ram_2r1w_if #(.AW(5), .DW(32)) ifa ();
    mor1kx_rf_ram_2r1w_if #(.AW(5), .DW(32)) ifb ();

    assign ifa.rdad_a_i = rdad_a;  assign ifb.rdad_a_i = rdad_a;
    assign ifa.rden_a_i = rden_a;  assign ifb.rden_a_i = rden_a;
    assign ifa.rdad_b_i = rdad_b;  assign ifb.rdad_b_i = rdad_b;
    assign ifa.rden_b_i = rden_b;  assign ifb.rden_b_i = rden_b;
    assign ifa.wrad_i   = wrad;    assign ifb.wrad_i   = wrad;
    assign ifa.wren_i   = wren;    assign ifb.wren_i   = wren;
    assign ifa.wrda_i   = wrda;    assign ifb.wrda_i   = wrda;

    mor1kx_rf_ram_2r1w #(
        .OPTION_OPERAND_WIDTH(32), .OPTION_RF_ADDR_WIDTH(5), .OPTION_RF_WORDS(32),
        .OPTION_RF_BYPASS(1), .OPTION_RF_CLEAR_ON_RESET(1)
    ) u_dut_a (.clk(clk), .rst(rst), .rf(ifa.slave));

    mor1kx_rf_ram_2r1w #(
        .OPTION_OPERAND_WIDTH(32), .OPTION_RF_ADDR_WIDTH(5), .OPTION_RF_WORDS(24),
        .OPTION_RF_BYPASS(0), .OPTION_RF_CLEAR_ON_RESET(1)
    ) u_dut_b (.clk(clk), .rst(rst), .rf(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rden_a = 1'b0; rden_b = 1'b0; wren = 1'b0;
        rdad_a = '0;   rdad_b = '0;   wrad = '0; wrda = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        exp_aa = '0; exp_ab = '0; exp_ba = '0; exp_bb = '0;
    endtask

    // dut 0: 32 words with bypass. dut 1: 24 words without bypass.
    function automatic logic [31:0] ref_read(input int dut, input logic [4:0] ra);
        int words;
        words = (dut == 0) ? 32 : 24;
        if (int'(ra) >= words) return '0;
        if (dut == 0 && wren && wrad == ra) return wrda;
        return (dut == 0) ? mem_a[ra] : mem_b[ra];
    endfunction

    task automatic cycle(input string tag);
        if (rden_a) begin exp_aa = ref_read(0, rdad_a); exp_ba = ref_read(1, rdad_a); end
        if (rden_b) begin exp_ab = ref_read(0, rdad_b); exp_bb = ref_read(1, rdad_b); end
        if (wren) begin
            if (int'(wrad) < 32) mem_a[wrad] = wrda;
            if (int'(wrad) < 24) mem_b[wrad] = wrda;
        end
        @(posedge clk); #1;
        chk({tag, "_a_porta"}, ifa.rdda_a_o, exp_aa);
        chk({tag, "_a_portb"}, ifa.rdda_b_o, exp_ab);
        chk({tag, "_b_porta"}, ifb.rdda_a_o, exp_ba);
        chk({tag, "_b_portb"}, ifb.rdda_b_o, exp_bb);
        chk({tag, "_busy"}, {30'd0, ifa.busy_o, ifb.busy_o}, 32'd0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle(); wren = 1'b1; wrad = a; wrda = d;
        cycle("wr");
        idle();
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b);
        idle(); rden_a = 1'b1; rdad_a = a; rden_b = 1'b1; rdad_b = b;
        cycle(tag);
        idle();
    endtask

    task automatic scan(input string tag);
        for (int i = 0; i < 32; i++) rd(tag, 5'(i), 5'(31 - i));
    endtask

    // Counts rising edges after reset release until each busy_o falls; 0 means it never fell.
    task automatic run_clear(input bit inject, output int fall_a, output int fall_b);
        fall_a = 0; fall_b = 0;
        for (int i = 1; i <= 100 && (fall_a == 0 || fall_b == 0); i++) begin
            idle();
            if (inject && i == 5) begin
                wren = 1'b1; wrad = 5'd3; wrda = 32'hDEADBEEF;
                rden_a = 1'b1; rdad_a = 5'd3; rden_b = 1'b1; rdad_b = 5'd3;
            end
            @(posedge clk); #1;
            if (fall_a == 0) begin
                chk("clear_a_rdda_a", ifa.rdda_a_o, 32'd0);
                if (!ifa.busy_o) fall_a = i;
            end
            if (fall_b == 0) begin
                chk("clear_b_rdda_a", ifb.rdda_a_o, 32'd0);
                if (!ifb.busy_o) fall_b = i;
            end
        end
        idle();
    endtask

    task automatic chk_in_reset(input string tag);
        chk({tag, "_a_rdda_a"}, ifa.rdda_a_o, 32'd0);
        chk({tag, "_a_rdda_b"}, ifa.rdda_b_o, 32'd0);
        chk({tag, "_b_rdda_a"}, ifb.rdda_a_o, 32'd0);
        chk({tag, "_b_rdda_b"}, ifb.rdda_b_o, 32'd0);
        chk({tag, "_busy"}, {30'd0, ifa.busy_o, ifb.busy_o}, 32'd3);
    endtask

    initial begin
        int fa, fb;
        rst = 1'b0;
        idle();
        model_clear();

        // Reset state and the clear sequence, with a request injected mid-clear
        repeat (3) @(posedge clk);
        #1;
        chk_in_reset("reset");
        rst = 1'b1;
        run_clear(1'b1, fa, fb);
        chk("clear_len_a", 32'(fa), 32'd32);
        chk("clear_len_b", 32'(fb), 32'd24);
        rd("clr_r3", 5'd3, 5'd3);
        chk("clr_r3_direct", ifa.rdda_a_o, 32'd0);
        scan("clr_scan");

        // Dual read of two words, then both ports hold when the enables drop
        wr(5'd1, 32'h11111111);
        wr(5'd2, 32'h22222222);
        rd("dual", 5'd1, 5'd2);
        chk("dual_a_direct", ifa.rdda_a_o, 32'h11111111);
        chk("dual_b_direct", ifa.rdda_b_o, 32'h22222222);
        idle();
        cycle("hold");
        chk("hold_a_direct", ifa.rdda_a_o, 32'h11111111);
        chk("hold_b_direct", ifb.rdda_b_o, 32'h22222222);

        // A same-cycle write and read of r7: forwarded on the bypass instance, old data on the other
        wr(5'd7, 32'hAAAAAAAA);
        idle(); wren = 1'b1; wrad = 5'd7; wrda = 32'h55555555;
        rden_a = 1'b1; rdad_a = 5'd7; rden_b = 1'b1; rdad_b = 5'd7;
        cycle("bypass");
        chk("byp_on_a",  ifa.rdda_a_o, 32'h55555555);
        chk("byp_on_b",  ifa.rdda_b_o, 32'h55555555);
        chk("byp_off_a", ifb.rdda_a_o, 32'hAAAAAAAA);
        chk("byp_off_b", ifb.rdda_b_o, 32'hAAAAAAAA);
        rd("after_byp", 5'd7, 5'd7);
        chk("after_byp_off", ifb.rdda_a_o, 32'h55555555);

        // Address 30 is past the end of the 24-word instance
        wr(5'd30, 32'h12345678);
        rd("oor", 5'd30, 5'd30);
        chk("oor_in_range_a", ifa.rdda_a_o, 32'h12345678);
        chk("oor_24w_a", ifb.rdda_a_o, 32'd0);
        chk("oor_24w_b", ifb.rdda_b_o, 32'd0);
        scan("oor_scan");

        // Random traffic, biased toward read/write address collisions
        for (int n = 0; n < 400; n++) begin
            wren   = 1'($urandom_range(0, 1));
            wrad   = 5'($urandom_range(0, 31));
            wrda   = $urandom;
            rden_a = ($urandom_range(0, 3) != 0);
            rdad_a = ($urandom_range(0, 3) == 0) ? wrad : 5'($urandom_range(0, 31));
            rden_b = ($urandom_range(0, 3) != 0);
            rdad_b = ($urandom_range(0, 3) == 0) ? wrad : 5'($urandom_range(0, 31));
            cycle("rand");
        end
        idle();
        scan("rand_scan");

        // Reset during operation, then reset again in the middle of the clear
        wr(5'd1, 32'hCAFEF00D);
        rd("pre_rst", 5'd1, 5'd1);
        rst = 1'b0;
        #1;
        chk_in_reset("rst_midop");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            chk("midclr_busy", {30'd0, ifa.busy_o, ifb.busy_o}, 32'd3);
        end
        rst = 1'b0;
        #1;
        chk_in_reset("rst_midclr");
        repeat (2) @(posedge clk);
        #1;
        chk_in_reset("rst_midclr_hold");
        rst = 1'b1;
        model_clear();
        run_clear(1'b0, fa, fb);
        chk("reclear_len_a", 32'(fa), 32'd32);
        chk("reclear_len_b", 32'(fb), 32'd24);
        scan("reclr_scan");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
